// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the line fill engine:
//   - request op encodings (op_e)
//   - engine state encoding (state_e)
//   - default line geometry constants (BYTES_PER_LINE, OFFSET_BITS, LINE_WIDTH)
//   - line_t: one whole cache line
// -----------------------------------------------------------------------------
package mem_if_pkg;

    localparam int BYTES_PER_LINE = 8;
    localparam int OFFSET_BITS    = $clog2(BYTES_PER_LINE);
    localparam int LINE_WIDTH     = 8 * BYTES_PER_LINE;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_WB_FILL = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_DRAIN,
        ST_RESP
    } state_e;

    typedef logic [LINE_WIDTH-1:0] line_t;

endpackage

// File: rtl/line_fill_engine_if.sv
// -----------------------------------------------------------------------------
// line_fill_engine_if
// Bundles the cache-side request/response port and the byte-wide memory port
// of the line fill engine.
//   master : the environment (cache controller + memory) side
//   slave  : the engine side
// Signals:
//   req_valid/req_ready/req_op/req_addr/req_wb_addr/req_wdata : line request
//   resp_valid/resp_rdata/resp_err                             : completion pulse
//   mem_addr/mem_wdata/mem_we/mem_rdata                        : byte memory bus
// -----------------------------------------------------------------------------
interface line_fill_engine_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int BYTES_PER_LINE = 8
);
    localparam int LINE_WIDTH = 8 * BYTES_PER_LINE;

    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] req_wb_addr;
    logic [LINE_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic [LINE_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  mem_we;
    logic [7:0]            mem_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_wb_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wb_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/line_byte_packer.sv
// -----------------------------------------------------------------------------
// line_byte_packer
// One cache line held as individually addressable bytes.
// Ports:
//   clk, srst     : clock, synchronous active-high reset (buffer -> 0)
//   i_clear       : zero the whole line (highest priority)
//   i_load        : load the whole line from i_load_line
//   i_wr_en       : write i_wr_byte into byte i_wr_idx
//   i_rd_idx      : byte index for o_rd_byte (reads the registered line)
//   o_rd_byte     : registered byte at i_rd_idx
//   o_line_next   : the line as it will be after this edge, so a caller can
//                   register the final line in the same cycle the last byte
//                   is written
// -----------------------------------------------------------------------------
module line_byte_packer #(
    parameter int BYTES_PER_LINE = 8
) (
    input  logic                              clk,
    input  logic                              srst,
    input  logic                              i_clear,
    input  logic                              i_load,
    input  logic [8*BYTES_PER_LINE-1:0]       i_load_line,
    input  logic                              i_wr_en,
    input  logic [$clog2(BYTES_PER_LINE)-1:0] i_wr_idx,
    input  logic [7:0]                        i_wr_byte,
    input  logic [$clog2(BYTES_PER_LINE)-1:0] i_rd_idx,
    output logic [7:0]                        o_rd_byte,
    output logic [8*BYTES_PER_LINE-1:0]       o_line_next
);
    localparam int IDX_BITS   = $clog2(BYTES_PER_LINE);
    localparam int LINE_WIDTH = 8 * BYTES_PER_LINE;

    logic [LINE_WIDTH-1:0] r_line;
    logic [LINE_WIDTH-1:0] w_line_next;
    logic [7:0]            w_bytes [BYTES_PER_LINE];

    generate
        for (genvar gi = 0; gi < BYTES_PER_LINE; gi++) begin : g_byte
            assign w_line_next[8*gi +: 8] =
                i_clear                                     ? 8'h00 :
                i_load                                      ? i_load_line[8*gi +: 8] :
                (i_wr_en && (i_wr_idx == IDX_BITS'(gi)))    ? i_wr_byte :
                                                              r_line[8*gi +: 8];
            assign w_bytes[gi] = r_line[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            r_line <= '0;
        end else begin
            r_line <= w_line_next;
        end
    end

    assign o_rd_byte   = w_bytes[i_rd_idx];
    assign o_line_next = w_line_next;

endmodule

// File: rtl/line_fill_engine.sv
// -----------------------------------------------------------------------------
// line_fill_engine
// Turns whole-line cache requests into byte-serial memory bursts:
//   READ     : 8 byte reads, line returned on resp_rdata
//   WRITE    : 8 byte writes
//   WB_FILL  : 8 byte writes of the victim, then 8 byte reads of the new line
//   reserved : immediate response with resp_err
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; aborts any burst, no response issued
//   bus  : line_fill_engine_if.slave (request, response and memory bus)
// All outputs are registered except req_ready, which is high only in IDLE.
// -----------------------------------------------------------------------------
module line_fill_engine #(
    parameter int ADDR_WIDTH     = 32,
    parameter int BYTES_PER_LINE = 8
) (
    input  logic                clk,
    input  logic                rst,
    line_fill_engine_if.slave   bus
);
    import mem_if_pkg::*;

    localparam int OFF_BITS   = $clog2(BYTES_PER_LINE);
    localparam int TAG_BITS   = ADDR_WIDTH - OFF_BITS;
    localparam int LINE_WIDTH = 8 * BYTES_PER_LINE;

    localparam logic [OFF_BITS-1:0] IDX_ZERO = '0;
    localparam logic [OFF_BITS-1:0] IDX_ONE  = OFF_BITS'(1);
    localparam logic [OFF_BITS-1:0] IDX_LAST = OFF_BITS'(BYTES_PER_LINE - 1);

    state_e                r_state;
    op_e                   r_op;
    logic [TAG_BITS-1:0]   r_wb_line;
    logic [TAG_BITS-1:0]   r_fill_line;
    logic [OFF_BITS-1:0]   r_cnt;

    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]            r_mem_wdata;
    logic                  r_mem_we;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [LINE_WIDTH-1:0] r_resp_rdata;

    op_e                   w_req_op;
    logic                  w_accept;
    logic                  w_is_wr_op;
    logic                  w_buf_clear;
    logic                  w_buf_load;
    logic                  w_buf_wr_en;
    logic [OFF_BITS-1:0]   w_buf_wr_idx;
    logic [OFF_BITS-1:0]   w_buf_rd_idx;
    logic [7:0]            w_buf_rd_byte;
    logic [LINE_WIDTH-1:0] w_buf_line_next;
    logic [TAG_BITS-1:0]   w_req_wb_line;
    logic [TAG_BITS-1:0]   w_req_fill_line;
    logic                  w_unused;

    assign w_req_op        = op_e'(bus.req_op);
    assign w_accept        = bus.req_valid && (r_state == ST_IDLE);
    assign w_is_wr_op      = (w_req_op == OP_WRITE) || (w_req_op == OP_WB_FILL);
    assign w_req_wb_line   = bus.req_wb_addr[ADDR_WIDTH-1:OFF_BITS];
    assign w_req_fill_line = bus.req_addr[ADDR_WIDTH-1:OFF_BITS];

    // Offset bits of the request addresses are deliberately ignored.
    assign w_unused = ^{bus.req_addr[OFF_BITS-1:0], bus.req_wb_addr[OFF_BITS-1:0]};

    // The buffer first carries the writeback line (serialised a byte at a time)
    // and is cleared before the fill bytes are collected into it.
    assign w_buf_load  = w_accept && w_is_wr_op;
    assign w_buf_clear = (w_accept && !w_is_wr_op) ||
                         ((r_state == ST_WR) && (r_cnt == IDX_LAST) && (r_op == OP_WB_FILL));

    // Read data lags the address by one cycle, so the byte arriving while the
    // counter shows k belongs to index k-1; DRAIN (counter back at 0) picks up
    // the last byte through the same wrap.
    assign w_buf_wr_en  = ((r_state == ST_RD) && (r_cnt != IDX_ZERO)) || (r_state == ST_DRAIN);
    assign w_buf_wr_idx = r_cnt - IDX_ONE;

    // Next byte to drive during a write burst.
    assign w_buf_rd_idx = r_cnt + IDX_ONE;

    line_byte_packer #(
        .BYTES_PER_LINE (BYTES_PER_LINE)
    ) u_packer (
        .clk         (clk),
        .srst        (rst),
        .i_clear     (w_buf_clear),
        .i_load      (w_buf_load),
        .i_load_line (bus.req_wdata),
        .i_wr_en     (w_buf_wr_en),
        .i_wr_idx    (w_buf_wr_idx),
        .i_wr_byte   (bus.mem_rdata),
        .i_rd_idx    (w_buf_rd_idx),
        .o_rd_byte   (w_buf_rd_byte),
        .o_line_next (w_buf_line_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_READ;
            r_wb_line    <= '0;
            r_fill_line  <= '0;
            r_cnt        <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op        <= w_req_op;
                        r_wb_line   <= w_req_wb_line;
                        r_fill_line <= w_req_fill_line;
                        r_cnt       <= '0;
                        case (w_req_op)
                            OP_WRITE, OP_WB_FILL: begin
                                r_state     <= ST_WR;
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= {w_req_wb_line, IDX_ZERO};
                                r_mem_wdata <= bus.req_wdata[7:0];
                            end
                            OP_READ: begin
                                r_state    <= ST_RD;
                                r_mem_we   <= 1'b0;
                                r_mem_addr <= {w_req_fill_line, IDX_ZERO};
                            end
                            default: begin
                                r_state      <= ST_RESP;
                                r_resp_valid <= 1'b1;
                                r_resp_err   <= 1'b1;
                                r_resp_rdata <= '0;
                            end
                        endcase
                    end
                end

                ST_WR: begin
                    if (r_cnt == IDX_LAST) begin
                        r_cnt    <= '0;
                        r_mem_we <= 1'b0;
                        if (r_op == OP_WB_FILL) begin
                            r_state    <= ST_RD;
                            r_mem_addr <= {r_fill_line, IDX_ZERO};
                        end else begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                            r_resp_rdata <= '0;
                        end
                    end else begin
                        r_cnt       <= r_cnt + IDX_ONE;
                        r_mem_addr  <= {r_wb_line, r_cnt + IDX_ONE};
                        r_mem_wdata <= w_buf_rd_byte;
                    end
                end

                ST_RD: begin
                    if (r_cnt == IDX_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_cnt      <= r_cnt + IDX_ONE;
                        r_mem_addr <= {r_fill_line, r_cnt + IDX_ONE};
                    end
                end

                ST_DRAIN: begin
                    r_state      <= ST_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= w_buf_line_next;
                end

                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_we     = r_mem_we;

endmodule

// File: tb/tb_line_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_line_fill_engine
// Drives line requests into line_fill_engine, plays the byte memory, and keeps
// a line-level reference of memory contents. Each accepted request pushes its
// expected response and memory-bus beats into queues; a monitor on the falling
// edge pops and compares whenever the engine presents them.
// -----------------------------------------------------------------------------
module tb_line_fill_engine;
    import mem_if_pkg::*;

    typedef struct {
        int          cyc;
        logic [63:0] rdata;
        bit          err;
    } resp_t;

    typedef struct {
        int          cyc;
        bit          we;
        logic [31:0] addr;
        logic [7:0]  data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    line_fill_engine_if #(.ADDR_WIDTH(32), .BYTES_PER_LINE(8)) bus ();

    line_fill_engine #(
        .ADDR_WIDTH     (32),
        .BYTES_PER_LINE (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    resp_t resp_q[$];
    beat_t beat_q[$];

    // Memory-side environment: untouched bytes read as mem_init(addr).
    logic [7:0] mem     [0:65535];
    bit         mem_wr  [0:65535];
    // Reference view of the same memory, updated per request.
    logic [7:0] ref_mem [0:65535];
    bit         ref_wr  [0:65535];

    int last_acc = 0;
    int last_lat = 0;

    function automatic void check(input string name, input bit ok,
                                  input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic logic [7:0] mem_init(input logic [31:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        if (lo >= 16'h1230 && lo <= 16'h1237) return 8'h10 + 8'(lo - 16'h1230);
        if (lo >= 16'h4008 && lo <= 16'h400F) return 8'hF0 + 8'(lo - 16'h4008);
        return 8'(lo * 16'd37) ^ lo[15:8];
    endfunction

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        logic [15:0] i;
        i = a[15:0];
        return mem_wr[i] ? mem[i] : mem_init(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        logic [15:0] i;
        i = a[15:0];
        return ref_wr[i] ? ref_mem[i] : mem_init(a);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[15:0]]    <= bus.mem_wdata;
            mem_wr[bus.mem_addr[15:0]] <= 1'b1;
        end
        bus.mem_rdata <= mem_rd(bus.mem_addr);
    end

    // Monitor: response pulses and memory-bus beats.
    always @(negedge clk) begin
        resp_t e;
        beat_t b;
        if (!rst) begin
            if (bus.resp_valid) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", 1'b0, 64'(bus.resp_valid), 64'd0);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_cycle", cyc == e.cyc, 64'(cyc), 64'(e.cyc));
                    check("resp_rdata", bus.resp_rdata == e.rdata, bus.resp_rdata, e.rdata);
                    check("resp_err", bus.resp_err == e.err, 64'(bus.resp_err), 64'(e.err));
                    $display("resp cyc=%0d rdata=0x%016h err=%0d", cyc, bus.resp_rdata, bus.resp_err);
                end
            end
            if (beat_q.size() > 0 && beat_q[0].cyc == cyc) begin
                b = beat_q.pop_front();
                check("mem_we", bus.mem_we == b.we, 64'(bus.mem_we), 64'(b.we));
                check("mem_addr", bus.mem_addr == b.addr, 64'(bus.mem_addr), 64'(b.addr));
                if (b.we) check("mem_wdata", bus.mem_wdata == b.data, 64'(bus.mem_wdata), 64'(b.data));
            end else if (bus.mem_we) begin
                check("mem_we_stray", 1'b0, 64'(bus.mem_we), 64'd0);
            end
        end
    end

    // Issue one request, wait for acceptance, record what the engine must do.
    task automatic issue(input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wb, input logic [63:0] wd, input bit chk);
        int          n;
        int          acc;
        int          lat;
        int          t;
        bit          does_wr;
        bit          does_rd;
        logic [31:0] wb_base;
        logic [31:0] fill_base;
        logic [31:0] a;
        logic [63:0] line;
        resp_t       r;
        beat_t       b;
        bus.req_valid   = 1'b1;
        bus.req_op      = op;
        bus.req_addr    = addr;
        bus.req_wb_addr = wb;
        bus.req_wdata   = wd;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 1'b0, 64'(bus.req_ready), 64'd1);
            bus.req_valid = 1'b0;
            return;
        end
        acc = cyc;
        if (chk) check("accept_cycle", acc == last_acc + last_lat + 1,
                       64'(acc), 64'(last_acc + last_lat + 1));

        does_wr   = (op == OP_WRITE) || (op == OP_WB_FILL);
        does_rd   = (op == OP_READ)  || (op == OP_WB_FILL);
        wb_base   = wb   & ~32'h7;
        fill_base = addr & ~32'h7;
        lat = 1 + (does_wr ? 8 : 0) + (does_rd ? 9 : 0);
        t = acc + 1;
        line = '0;
        if (does_wr) begin
            for (int i = 0; i < 8; i++) begin
                a = wb_base + 32'(i);
                ref_mem[a[15:0]] = wd[8*i +: 8];
                ref_wr[a[15:0]]  = 1'b1;
                b.cyc = t; b.we = 1'b1; b.addr = a; b.data = wd[8*i +: 8];
                beat_q.push_back(b);
                t++;
            end
        end
        if (does_rd) begin
            for (int i = 0; i < 8; i++) begin
                a = fill_base + 32'(i);
                line[8*i +: 8] = ref_rd(a);
                b.cyc = t; b.we = 1'b0; b.addr = a; b.data = 8'h00;
                beat_q.push_back(b);
                t++;
            end
        end
        r.cyc   = acc + lat;
        r.rdata = line;
        r.err   = (op == OP_RSVD);
        resp_q.push_back(r);
        last_acc = acc;
        last_lat = lat;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((resp_q.size() > 0 || beat_q.size() > 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (resp_q.size() > 0 || beat_q.size() > 0) begin
            check("drain_timeout", 1'b0, 64'(resp_q.size()), 64'd0);
            resp_q.delete();
            beat_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r;
        bit          chk_next;
        logic [1:0]  op;
        logic [31:0] fa;
        logic [31:0] wa;
        logic [63:0] wd;

        bus.req_valid   = 1'b0;
        bus.req_op      = 2'b00;
        bus.req_addr    = '0;
        bus.req_wb_addr = '0;
        bus.req_wdata   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready == 1'b1, 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", bus.resp_valid == 1'b0, 64'(bus.resp_valid), 64'd0);
        check("rst_mem_we", bus.mem_we == 1'b0, 64'(bus.mem_we), 64'd0);
        check("rst_mem_addr", bus.mem_addr == 32'd0, 64'(bus.mem_addr), 64'd0);
        check("rst_resp_rdata", bus.resp_rdata == 64'd0, bus.resp_rdata, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed: READ, WRITE, WB_FILL followed by a held READ.
        issue(OP_READ, 32'h0000_1235, 32'h0, 64'h0, 1'b0);
        drain();
        issue(OP_WRITE, 32'h0, 32'h0000_2000, 64'hA7A6_A5A4_A3A2_A1A0, 1'b0);
        drain();
        issue(OP_WB_FILL, 32'h0000_4008, 32'h0000_3000, 64'h0123_4567_89AB_CDEF, 1'b0);
        issue(OP_READ, 32'h0000_3000, 32'h0, 64'h0, 1'b1);
        drain();
        check("mem_3000", mem_rd(32'h3000) == 8'hEF, 64'(mem_rd(32'h3000)), 64'hEF);
        check("mem_3007", mem_rd(32'h3007) == 8'h01, 64'(mem_rd(32'h3007)), 64'h01);

        // Reserved op, then aliasing writeback/fill.
        issue(OP_RSVD, 32'h0000_7000, 32'h0000_7100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        drain();
        issue(OP_WB_FILL, 32'h0000_5000, 32'h0000_5000, 64'h8877_6655_4433_2211, 1'b0);
        drain();

        // Randomised back-to-back traffic over a small set of lines.
        chk_next = 1'b0;
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            op = (r < 3) ? OP_READ : (r < 6) ? OP_WRITE : (r < 9) ? OP_WB_FILL : OP_RSVD;
            fa = {16'($urandom), 16'h6000 + 16'($urandom_range(0, 63))};
            wa = ($urandom_range(0, 3) == 0) ? fa
                 : {16'($urandom), 16'h6000 + 16'($urandom_range(0, 63))};
            wd = {$urandom, $urandom};
            issue(op, fa, wa, wd, chk_next);
            chk_next = 1'b1;
            if ($urandom_range(0, 4) == 0) begin
                drain();
                chk_next = 1'b0;
            end
        end
        drain();

        // Reset in the middle of a write burst, with a request held meanwhile.
        issue(OP_WRITE, 32'h0, 32'h0000_9000, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        resp_q.delete();
        beat_q.delete();
        bus.req_valid = 1'b1;
        bus.req_op    = OP_READ;
        bus.req_addr  = 32'h0000_1230;
        @(posedge clk);
        @(negedge clk);
        check("midrst_mem_we", bus.mem_we == 1'b0, 64'(bus.mem_we), 64'd0);
        check("midrst_resp_valid", bus.resp_valid == 1'b0, 64'(bus.resp_valid), 64'd0);
        check("midrst_req_ready", bus.req_ready == 1'b1, 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("postrst_req_ready", bus.req_ready == 1'b1, 64'(bus.req_ready), 64'd1);
        check("postrst_mem_we", bus.mem_we == 1'b0, 64'(bus.mem_we), 64'd0);
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/line_fill_engine.md
Name: line_fill_engine

Overview:
- Sits between the cache controller and the byte-wide main memory.
- Converts whole-line cache requests into byte-serial memory bursts: fill (read line), writeback (write line), and combined writeback-then-fill (eviction of a dirty victim).
- A line is 64 bits (8 bytes); addresses are 32 bits.
- Gives the cache a valid/ready request port and a one-cycle response pulse, replacing the zero-time memory access loops in the cache.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- BYTES_PER_LINE, 8, bytes per cache line (power of two).
- LINE_WIDTH, 64, 8*BYTES_PER_LINE; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  cache request valid.
- req_ready  out  1  engine can accept a request.
- req_op  in  2  00 READ, 01 WRITE, 10 WB_FILL, 11 reserved.
- req_addr  in  ADDR_WIDTH  fill line address; offset bits ignored.
- req_wb_addr  in  ADDR_WIDTH  writeback line address; offset bits ignored.
- req_wdata  in  LINE_WIDTH  writeback line data; byte i = bits [8i+7:8i].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  LINE_WIDTH  filled line; valid with resp_valid.
- resp_err  out  1  reserved op flagged; valid with resp_valid.
- mem_addr  out  ADDR_WIDTH  byte address to memory.
- mem_wdata  out  8  byte to write.
- mem_we  out  1  write strobe, one byte per cycle.
- mem_rdata  in  8  read byte; valid one cycle after mem_addr is presented with mem_we=0.

Behaviour:
- All outputs are registered except req_ready, which is (state==IDLE).
- Reset values: state IDLE; resp_valid, resp_err, mem_we = 0; mem_addr, mem_wdata, resp_rdata = 0; byte counter 0.
- States: IDLE, WR, RD, DRAIN, RESP.
- IDLE:
  - On req_valid && req_ready, latch op, both line addresses with offset forced to 0, and wdata. Clear the line buffer.
  - Next state: WRITE or WB_FILL -> WR; READ -> RD; reserved -> RESP with resp_err=1.
- WR, 8 cycles, counter k=0..7:
  - mem_we=1, mem_addr={wb_line, k}, mem_wdata=wdata byte k.
  - After k=7: WRITE -> RESP; WB_FILL -> RD with counter reset to 0.
- RD, 8 cycles, counter k=0..7:
  - mem_we=0, mem_addr={fill_line, k}.
  - From the second RD cycle on, capture mem_rdata into buffer byte k-1.
  - After k=7 -> DRAIN.
- DRAIN, 1 cycle: capture byte 7, mem_we=0, then -> RESP.
- RESP, 1 cycle:
  - resp_valid=1.
  - resp_rdata = buffer for READ and WB_FILL; 0 for WRITE and reserved.
  - Then -> IDLE.
- Latency, with the handshake in cycle 0:
  - READ: resp_valid in cycle 10.
  - WRITE: resp_valid in cycle 9.
  - WB_FILL: resp_valid in cycle 18.
  - Reserved: resp_valid in cycle 1.
- Handshake rules:
  - One request outstanding. req_ready is low from the cycle after acceptance through RESP.
  - The earliest next acceptance is the IDLE cycle after RESP.
  - Request inputs are ignored while not ready.
- No response backpressure. The cache must sample resp_valid every cycle.
- The counter is log2(BYTES_PER_LINE) bits and wraps to 0 only on state exit; no mid-burst wrap.
- Address arithmetic:
  - Line base = addr with the low log2(BYTES_PER_LINE) bits cleared.
  - The counter is concatenated into those bits; no carry into the tag or index.
- The writeback address equal to the fill address is legal: the fill returns the just-written data.
- mem_we is never high outside WR. mem_addr holds its last value in IDLE and RESP.
- Reset mid-operation:
  - At the reset edge, outputs take reset values and the burst aborts.
  - Memory may hold a partial write; no response is issued.
  - req_ready is high in the cycle after reset deasserts.
- req_valid held with reset high: not accepted.

Decomposition:
- Package mem_if_pkg holds:
  - op encodings OP_READ, OP_WRITE, OP_WB_FILL, OP_RSVD;
  - state enum;
  - BYTES_PER_LINE and OFFSET_BITS constants;
  - line type (LINE_WIDTH vector).
- One natural sub-module, line_byte_packer. It holds the 64-bit buffer and provides:
  - clear;
  - write byte at index;
  - read byte at index (used for the serialised wdata).
- The FSM and counter stay in line_fill_engine.

Test Plan:
- Reset: assert rst 2 cycles mid-WR burst (k=3) -> next cycle mem_we=0, resp_valid=0, req_ready=1; no resp_valid for 20 cycles.
- READ 0x0000_1235, memory bytes 0x1230..0x1237 = 0x10..0x17:
  - mem_addr runs 0x1230..0x1237 in cycles 1-8, mem_we=0;
  - cycle 10: resp_valid=1, resp_rdata=0x1716151413121110.
- WRITE wb_addr 0x0000_2000, wdata 0xA7A6A5A4A3A2A1A0:
  - cycles 1-8: mem_we=1, addresses 0x2000..0x2007, bytes 0xA0..0xA7;
  - cycle 9: resp_valid=1, rdata=0, err=0.
- WB_FILL wb 0x3000 (wdata 0x0123456789ABCDEF), fill 0x4008 (memory 0xF0..0xF7):
  - 8 writes then 8 reads;
  - resp_valid in cycle 18, rdata=0xF7F6F5F4F3F2F1F0;
  - memory 0x3000 = 0xEF, 0x3007 = 0x01.
- Handshake: hold req_valid high with a new READ during a busy op -> not accepted until the IDLE cycle after RESP; reserved op 11 -> resp_valid and resp_err=1 in cycle 1, no mem_we.
- Aliasing: WB_FILL with wb = fill = 0x5000, wdata 0x8877665544332211 -> resp_rdata=0x8877665544332211.
